alu_chain_seq: RTL and testbench
================================

Name: alu_chain_seq

Overview:
- Multi-byte arithmetic/shift sequencer that sits directly upstream of the 8-bit ALU.
- Accepts a NBYTES-wide operation, then drives the ALU's command, operand and shift_carry-in inputs one byte per cycle.
- Consumes the ALU's result, carry-out, zero and parity outputs each cycle, chaining carry-out into the next byte's carry-in.
- Presents the assembled wide result and aggregate flags with a done pulse.

Parameters:
NBYTES, 2, number of 8-bit bytes per operand (legal 1..8).

Ports:
clk  input  1  sole clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  00 ADD, 01 SUB, 10 SHL, 11 SHR
a_word  input  8*NBYTES  operand A, little-endian bytes
b_word  input  8*NBYTES  operand B, ignored for shifts
cin  input  1  initial carry (ADD) or shift-in bit (SHL/SHR); ignored for SUB
alu_cmd  output  3  to ALU; 000 for ADD/SUB, 001 SHL, 010 SHR
alu_a  output  8  to ALU inA
alu_b  output  8  to ALU inB
alu_sc_i  output  1  to ALU sc_i
alu_how_high  output  2  to ALU immediate; constant 0
alu_rslt  input  8  from ALU
alu_sc_o  input  1  from ALU
alu_zero  input  1  from ALU
alu_pari  input  1  from ALU
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
result  output  8*NBYTES  assembled result, held until next accepted start
cout  output  1  final carry/shift-out bit
zero_f  output  1  1 iff every result byte was zero
pari_f  output  1  XOR of all byte parities

Behaviour:
- Reset (asynchronous, active-low, effective mid-operation):
  - state IDLE.
  - busy, done, cout, zero_f, pari_f, result, byte index and carry register all 0.
  - alu_* outputs 0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On rising edge with start=1: latch a_word, b_word, op.
  - Clear result; set zero_f=1, pari_f=0.
  - Load carry register: cin for ADD/SHL/SHR, 1 for SUB.
  - Set index to first byte; go to RUN.
- RUN:
  - alu_a = latched A byte[idx].
  - alu_b = B byte[idx] for ADD, ~B byte[idx] for SUB (SUB is A + ~B + 1), 0 for shifts.
  - alu_sc_i = carry register.
  - Each edge:
    - result byte[idx] <= alu_rslt.
    - carry <= alu_sc_o.
    - zero_f <= zero_f & alu_zero.
    - pari_f <= pari_f ^ alu_pari.
  - Byte order: ADD/SUB/SHL process byte 0 upward; SHR processes byte NBYTES-1 downward.
  - After the last byte's edge, go to DONE with cout = final carry.
- DONE: done=1 for exactly one cycle; busy=0; then IDLE.
- SUB cout semantics: 1 = no borrow (A >= B); 0 = borrow.
- Latency: start sampled at edge 0; edges 1..NBYTES capture bytes; done high during the cycle following edge NBYTES.
- Outside RUN, alu_* outputs are 0.
- start while in RUN or DONE is ignored; no queuing. Operand changes after acceptance have no effect.
- result/cout/zero_f/pari_f remain stable from DONE until the next accepted start, including across idle cycles.
- NBYTES=1: single RUN cycle; identical to one direct ALU op (except SUB encoding).

Test Plan:
- NBYTES=2, ADD a=0x00FF b=0x0001 cin=0 -> result=0x0100, cout=0, zero_f=0, pari_f=1. busy high 2 cycles, done high in the 3rd cycle after the start edge.
- SUB a=0x0100 b=0x0001 -> result=0x00FF, cout=1. SUB a=0x0000 b=0x0001 -> result=0xFFFF, cout=0, pari_f=0.
- SHL a=0x8001 cin=1 -> result=0x0003, cout=1. SHR a=0x0001 cin=1 -> result=0x8000, cout=1; alu_a shows 0x00 then 0x01 (MS byte first).
- ADD a=0xFFFF b=0x0001 cin=0 -> result=0x0000, cout=1, zero_f=1, pari_f=0.
- start held high through RUN with new operands -> exactly one done pulse and first operation's result. Back-to-back start in the cycle after done is accepted.
- Assert reset mid-RUN (after byte 0) -> all outputs 0 immediately, without a clock edge; no done pulse. Fresh start after release completes correctly.

Source files
------------

// File: rtl/alu_chain_seq.sv
// Multi-byte sequencer feeding an external 8-bit ALU one byte per cycle,
// chaining carry-out to carry-in and assembling the wide result and flags.
module alu_chain_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [8*NBYTES-1:0]   a_word,
  input  logic [8*NBYTES-1:0]   b_word,
  input  logic                  cin,
  output logic [2:0]            alu_cmd,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_sc_i,
  output logic [1:0]            alu_how_high,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sc_o,
  input  logic                  alu_zero,
  input  logic                  alu_pari,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  zero_f,
  output logic                  pari_f
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [NBYTES-1:0][7:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]                op_q, op_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic                      zero_q, zero_d;
  logic                      pari_q, pari_d;
  logic                      last_byte;

  // SHR walks from the MS byte down, so its final byte is index 0.
  assign last_byte = (op_q == OP_SHR) ? (idx_q == '0) : (idx_q == LAST);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    pari_d  = pari_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a_word;
        b_d     = b_word;
        op_d    = op;
        res_d   = '0;
        zero_d  = 1'b1;
        pari_d  = 1'b0;
        carry_d = (op == OP_SUB) ? 1'b1 : cin;
        idx_d   = (op == OP_SHR) ? LAST : '0;
        state_d = RUN;
      end
      RUN: begin
        res_d[idx_q] = alu_rslt;
        carry_d      = alu_sc_o;
        zero_d       = zero_q & alu_zero;
        pari_d       = pari_q ^ alu_pari;
        if (last_byte)           state_d = DONE;
        else if (op_q == OP_SHR) idx_d = idx_q - IW'(1);
        else                     idx_d = idx_q + IW'(1);
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      pari_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      pari_q  <= pari_d;
      res_q   <= res_d;
    end
  end

  // ALU drive is purely combinational from state so reset clears it at once.
  always_comb begin
    alu_cmd  = 3'b000;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_sc_i = 1'b0;
    if (state_q == RUN) begin
      alu_a    = a_q[idx_q];
      alu_sc_i = carry_q;
      case (op_q)
        OP_ADD:  alu_b = b_q[idx_q];
        OP_SUB:  alu_b = ~b_q[idx_q];
        OP_SHL:  alu_cmd = 3'b001;
        OP_SHR:  alu_cmd = 3'b010;
        default: alu_cmd = 3'b000;
      endcase
    end
  end

  assign alu_how_high = 2'b00;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = res_q;
  // carry register is frozen outside RUN, so it doubles as the final cout.
  assign cout   = carry_q;
  assign zero_f = zero_q;
  assign pari_f = pari_q;
endmodule

// File: tb/tb_alu_chain_seq.sv
// Directed bench for alu_chain_seq (NBYTES=2) with a behavioural 8-bit ALU.
module tb_alu_chain_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a_word, b_word;
  logic        cin;
  logic [2:0]  alu_cmd;
  logic [7:0]  alu_a, alu_b, alu_rslt;
  logic        alu_sc_i, alu_sc_o, alu_zero, alu_pari;
  logic [1:0]  alu_how_high;
  logic        busy, done, cout, zero_f, pari_f;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;
  int nbusy, ndone, done_at;
  logic [7:0] alog [0:7];

  always #5 clk = ~clk;

  alu_chain_seq #(.NBYTES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_word(a_word), .b_word(b_word), .cin(cin),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_sc_i(alu_sc_i),
    .alu_how_high(alu_how_high), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o),
    .alu_zero(alu_zero), .alu_pari(alu_pari),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .zero_f(zero_f), .pari_f(pari_f)
  );

  // Reference ALU: 000 add with carry, 001 shift left, 010 shift right.
  always_comb begin
    {alu_sc_o, alu_rslt} = 9'h000;
    case (alu_cmd)
      3'b000: {alu_sc_o, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_sc_i};
      3'b001: {alu_sc_o, alu_rslt} = {alu_a, alu_sc_i};
      3'b010: begin alu_rslt = {alu_sc_i, alu_a[7:1]}; alu_sc_o = alu_a[0]; end
      default: ;
    endcase
    alu_zero = (alu_rslt == 8'h00);
    alu_pari = ^alu_rslt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation; optionally keep start high and scramble operands
  // after acceptance. Returns when done is seen or the budget expires.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input bit hold);
    @(negedge clk);
    op = o; a_word = a; b_word = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      a_word = 16'($urandom); b_word = 16'($urandom); op = 2'($urandom); cin = ~c;
    end else start = 1'b0;
    nbusy = 0; ndone = 0; done_at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin alog[nbusy[2:0]] = alu_a; nbusy++; end
      if (done) begin ndone++; done_at = i; start = 1'b0; break; end
    end
    chk("done_seen", 32'(ndone), 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic co,
                         input logic z, input logic p);
    chk({tag, "_result"}, 32'(result), 32'(r));
    chk({tag, "_cout"},   32'(cout),   32'(co));
    chk({tag, "_zero"},   32'(zero_f), 32'(z));
    chk({tag, "_pari"},   32'(pari_f), 32'(p));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; a_word = '0; b_word = '0; cin = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({cout, zero_f, pari_f}), 32'd0);
    chk("rst_alu", 32'({alu_cmd, alu_a, alu_b, alu_sc_i, alu_how_high}), 32'd0);
    @(negedge clk); reset = 1'b1;

    run_op(2'b00, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    chk("add1_busy_cycles", 32'(nbusy), 32'd2);
    chk("add1_done_cycle", 32'(done_at), 32'd2);
    chk("add1_busy_in_done", 32'(busy), 32'd0);
    chk_out("add1", 16'h0100, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("add1_done_pulse", 32'(done), 32'd0);

    run_op(2'b01, 16'h0100, 16'h0001, 1'b0, 1'b0);
    chk_out("sub1", 16'h00FF, 1'b1, 1'b0, 1'b0);
    run_op(2'b01, 16'h0000, 16'h0001, 1'b1, 1'b0);
    chk_out("sub2", 16'hFFFF, 1'b0, 1'b0, 1'b0);

    run_op(2'b10, 16'h8001, 16'hFFFF, 1'b1, 1'b0);
    chk_out("shl", 16'h0003, 1'b1, 1'b0, 1'b0);
    run_op(2'b11, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    chk_out("shr", 16'h8000, 1'b1, 1'b0, 1'b1);
    chk("shr_alu_a0", 32'(alog[0]), 32'h00);
    chk("shr_alu_a1", 32'(alog[1]), 32'h01);

    run_op(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk_out("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk_out("hold_idle", 16'h0000, 1'b1, 1'b1, 1'b0);

    // start held through RUN with changing operands
    run_op(2'b00, 16'h1234, 16'h0101, 1'b0, 1'b1);
    chk("held_busy_cycles", 32'(nbusy), 32'd2);
    chk_out("held", 16'h1335, 1'b0, 1'b0, 1'b1);
    // next start lands in the cycle right after done
    run_op(2'b01, 16'h0005, 16'h0003, 1'b0, 1'b0);
    chk("b2b_done_cycle", 32'(done_at), 32'd2);
    chk_out("b2b", 16'h0002, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_no_extra_done", 32'(done), 32'd0);

    // asynchronous reset after the first byte is captured
    @(negedge clk);
    op = 2'b00; a_word = 16'h1234; b_word = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk("mid_byte0", 32'(result), 32'h0045);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_flags", 32'({done, cout, zero_f, pari_f}), 32'd0);
    chk("arst_alu", 32'({alu_cmd, alu_a, alu_b, alu_sc_i}), 32'd0);
    ndone = 0;
    repeat (3) begin @(negedge clk); if (done) ndone++; end
    chk("arst_no_done", 32'(ndone), 32'd0);
    reset = 1'b1;

    run_op(2'b00, 16'h00FF, 16'h0001, 1'b1, 1'b0);
    chk_out("post_rst", 16'h0101, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
